// File: rtl/versatile_io_wb_byte_master.sv
// Wishbone classic initiator: turns one byte command into one 32-bit single cycle.
// Write data is replicated to all lanes; read data comes from the address-selected lane.
module versatile_io_wb_byte_master #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        wbm_clk,
    input  logic        wbm_rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [7:0]  cmd_dat,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_dat,
    output logic        rsp_err,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_stb_o,
    output logic        wbm_cyc_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t      r_state, w_next;
    logic [15:0] r_cnt, w_cnt;
    logic        r_cmd_ready, w_cmd_ready;
    logic        r_rsp_valid, w_rsp_valid;
    logic [7:0]  r_rsp_dat, w_rsp_dat;
    logic        r_rsp_err, w_rsp_err;
    logic [31:0] r_adr, w_adr;
    logic [31:0] r_wdat, w_wdat;
    logic [3:0]  r_sel, w_sel;
    logic        r_we, w_we;
    logic        r_cyc, w_cyc;
    logic        w_accept;
    logic        w_timeout;
    logic [7:0]  w_lane;

    assign w_accept  = (r_state == IDLE) && cmd_valid && r_cmd_ready;
    // Counter value is the number of ack-less BUS cycles already elapsed
    assign w_timeout = (TIMEOUT != 0) && (({1'b0, r_cnt} + 17'd1) == 17'(TIMEOUT));

    always_comb begin
        case (r_adr[1:0])
            2'd0:    w_lane = wbm_dat_i[31:24];
            2'd1:    w_lane = wbm_dat_i[23:16];
            2'd2:    w_lane = wbm_dat_i[15:8];
            default: w_lane = wbm_dat_i[7:0];
        endcase
    end

    always_ff @(posedge wbm_clk) begin
        if (wbm_rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b0;
            r_adr       <= '0;
            r_wdat      <= '0;
            r_sel       <= '0;
            r_we        <= 1'b0;
            r_cyc       <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cnt       <= w_cnt;
            r_cmd_ready <= w_cmd_ready;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_dat   <= w_rsp_dat;
            r_rsp_err   <= w_rsp_err;
            r_adr       <= w_adr;
            r_wdat      <= w_wdat;
            r_sel       <= w_sel;
            r_we        <= w_we;
            r_cyc       <= w_cyc;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = BUS;
            BUS:     if (wbm_ack_i || w_timeout) w_next = RESP;
            RESP:    if (r_rsp_valid && rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Next values of the registered outputs, derived from the state transition
    always_comb begin
        w_cmd_ready = (w_next == IDLE);
        w_rsp_valid = (w_next == RESP);
        w_cyc       = (w_next == BUS);
        w_cnt       = r_cnt;
        w_rsp_dat   = r_rsp_dat;
        w_rsp_err   = r_rsp_err;
        w_adr       = r_adr;
        w_wdat      = r_wdat;
        w_sel       = r_sel;
        w_we        = r_we;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_adr  = cmd_adr;
                    w_wdat = {4{cmd_dat}};
                    w_sel  = 4'b1000 >> cmd_adr[1:0];
                    w_we   = cmd_we;
                    w_cnt  = '0;
                end
            end
            BUS: begin
                if (wbm_ack_i) begin
                    w_rsp_dat = r_we ? 8'h00 : w_lane;
                    w_rsp_err = 1'b0;
                    w_sel     = '0;
                    w_we      = 1'b0;
                end else begin
                    w_cnt = r_cnt + 16'd1;
                    if (w_timeout) begin
                        w_rsp_dat = 8'h00;
                        w_rsp_err = 1'b1;
                        w_sel     = '0;
                        w_we      = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_dat   = r_rsp_dat;
    assign rsp_err   = r_rsp_err;
    assign wbm_adr_o = r_adr;
    assign wbm_dat_o = r_wdat;
    assign wbm_sel_o = r_sel;
    assign wbm_we_o  = r_we;
    assign wbm_stb_o = r_cyc;
    assign wbm_cyc_o = r_cyc;

endmodule
